ge_p3_tobytes: RTL and testbench
================================

GE_P3_TOBYTES -- requirements
Module: ge_p3_tobytes

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: valid  in  1  start request, sampled only in IDLE.
REQ-004 SHALL have ports: h_x, h_y, h_z  in  320 each  projective point (X:Y:Z); 10 signed 32-bit limbs, limb i at [32i +: 32], radix 2^25.5.
REQ-005 SHALL have ports: s  out  256  encoded point; byte k at [8k +: 8].
REQ-006 SHALL have ports: done  out  1  one-cycle pulse when s is valid.
REQ-007 SHALL have ports: busy  out  1  high from accept until the done cycle, inclusive.
REQ-008 SHALL have ports: mul_op_a, mul_op_b  out  320  shared field-multiplier operands.
REQ-009 SHALL have ports: mul_valid  out  1  one-cycle multiply request.
REQ-010 SHALL have ports: mul_res  in  320  and  mul_done  in  1  multiplier result and completion strobe.

Function
REQ-011 SHALL compute recip = Z^(p-2) mod p, with p = 2^255-19; x = X*recip; y = Y*recip; s = fe_tobytes(y) with bit 255 replaced by fe_isnegative(x).
REQ-012 SHALL use the existing fe_tobytes/fe_isnegative common functions combinationally; all multiplies go through the shared multiplier port.
REQ-013 SHALL latch h_x, h_y, h_z on the accept cycle (IDLE and valid=1); later input changes have no effect.
REQ-014 SHALL implement inversion as left-to-right square-and-multiply over exponent p-2 = 0x7FFF...FFEB: acc = Z (bit 254); for i = 253 down to 0: acc = acc^2, then acc = acc*Z if bit i = 1.
REQ-015 SHALL use an 8-bit bit-index counter; exponent bits: 254..5 all 1, bits 4..0 = 01011.
REQ-016 SHALL have states: IDLE, INV_SQ, INV_MUL, MUL_X, MUL_Y, PACK.
REQ-017 SHALL follow transitions: IDLE->INV_SQ on accept; INV_SQ->INV_MUL if bit=1, else next bit; INV_MUL->INV_SQ, or ->MUL_X after bit 0; MUL_X->MUL_Y->PACK->IDLE.
REQ-018 SHALL, for each multiply, pulse mul_valid for exactly one cycle; hold mul_op_a/b stable until mul_done; issue no new request before mul_done.
REQ-019 SHALL ignore mul_done when no request is outstanding.
REQ-020 SHALL issue exactly 508 mul_valid pulses per operation: 254 squarings + 252 multiply-by-Z + 2 final.
REQ-021 SHALL, in PACK, register s and pulse done in the same cycle; s holds until the next done.
REQ-022 SHALL ignore valid while busy; valid asserted in the done cycle is not accepted (busy still high).
REQ-023 SHALL, for Z = 0, yield recip = 0 and s = 256'h0, with no error indication and normal latency.
REQ-024 SHALL have latency, with a fixed multiplier latency L (valid to done): 508*(L+1) + 2 cycles from accept to done.

Reset
REQ-025 SHALL, while rst=0, set state IDLE, done=0, busy=0, mul_valid=0, s=0, mul_op_a=0, mul_op_b=0, and counter=254.
REQ-026 SHALL, on reset mid-operation, abandon the operation without emitting done; a multiplier result arriving after reset is ignored.
REQ-027 SHALL accept valid on the first cycle after rst returns high.

Verification
REQ-028 SHALL pass: base point B, Z=1 -> s = 256'h6666666666666666666666666666666666666666666666666666666666666658; one done pulse.
REQ-029 SHALL pass: identity (0:1:1) -> s = 256'h0000...0001; sign bit 0.
REQ-030 SHALL pass: B scaled by k=7 ((7X:7Y:7Z) mod p) -> same s as REQ-028; -B (negated X) -> same s with bit 255 set.
REQ-031 SHALL pass: Z=0 -> s = 0; exactly 508 mul_valid pulses counted; latency matches REQ-024 for L = 1 and L = 5.
REQ-032 SHALL pass: reset asserted after 100 multiplies -> no done, outputs at reset values; next request after release completes correctly.
REQ-033 SHALL pass: valid held high throughout and h_* changed mid-operation -> result uses the accepted inputs; next operation starts only after done.

Source files
------------

// File: rtl/ge_p3_tobytes_if.sv
// Request/result bus of ge_p3_tobytes together with its shared field-multiplier port.
interface ge_p3_tobytes_if;
  logic         valid;
  logic [319:0] h_x;
  logic [319:0] h_y;
  logic [319:0] h_z;
  logic [255:0] s;
  logic         done;
  logic         busy;
  logic [319:0] mul_op_a;
  logic [319:0] mul_op_b;
  logic         mul_valid;
  logic [319:0] mul_res;
  logic         mul_done;

  // Requester side: issues points and owns the field multiplier.
  modport master (
    output valid, h_x, h_y, h_z, mul_res, mul_done,
    input  s, done, busy, mul_op_a, mul_op_b, mul_valid
  );

  // Encoder side.
  modport slave (
    input  valid, h_x, h_y, h_z, mul_res, mul_done,
    output s, done, busy, mul_op_a, mul_op_b, mul_valid
  );
endinterface

// File: rtl/ge_p3_tobytes.sv
// Projective Ed25519 point (X:Y:Z) -> 32-byte encoding.
// Z is inverted by square-and-multiply over p-2 on an external shared multiplier,
// then x = X/Z and y = Y/Z are formed and y is packed with the sign of x in bit 255.
module ge_p3_tobytes (
  input logic            clk,
  input logic            rst,
  ge_p3_tobytes_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INV_SQ, INV_MUL, MUL_X, MUL_Y, PACK} state_t;

  // Low five bits of p-2; bits 254..5 are all ones.
  localparam logic [7:0]   EXP_LOW      = 8'b0000_1011;
  localparam logic [255:0] PAYLOAD_MASK = {1'b0, {255{1'b1}}};

  // Canonical little-endian encoding of a 10-limb (26/25-bit alternating) element.
  function automatic logic [255:0] fe_tobytes(input logic [319:0] h);
    logic signed [31:0] t [10];
    logic signed [31:0] q;
    logic signed [31:0] c;
    logic [255:0]       r;
    for (int i = 0; i < 10; i++) t[i] = h[32*i +: 32];
    // q ends up as floor(h / p): 1 exactly when the value sits in [p, 2^255).
    q = (32'sd19 * t[9] + 32'sd16777216) >>> 25;
    for (int i = 0; i < 10; i++) q = (t[i] + q) >>> ((i % 2 == 0) ? 26 : 25);
    t[0] = t[0] + 32'sd19 * q;
    for (int i = 0; i < 9; i++) begin
      c      = t[i] >>> ((i % 2 == 0) ? 26 : 25);
      t[i+1] = t[i+1] + c;
      t[i]   = t[i] - (c <<< ((i % 2 == 0) ? 26 : 25));
    end
    c    = t[9] >>> 25;
    t[9] = t[9] - (c <<< 25);
    r = '0;
    for (int i = 0; i < 10; i++) r = r | (256'(unsigned'(t[i])) << (25*i + (i+1)/2));
    return r;
  endfunction

  // Sign of an element: low bit of its canonical encoding.
  function automatic logic fe_isnegative(input logic [319:0] h);
    logic [255:0] b;
    b = fe_tobytes(h);
    return b[0];
  endfunction

  state_t       state;
  logic [7:0]   cnt;
  logic         pend;
  logic [319:0] x_l, y_l, z_l;
  logic [319:0] acc;
  logic         xneg;
  logic [255:0] s_r;
  logic         done_r, busy_r, mv_r;
  logic [319:0] op_a, op_b;

  logic         cur_bit;
  logic         mul_go;
  logic [255:0] acc_bytes;

  // Exponent bit at the current ladder position.
  assign cur_bit   = (cnt >= 8'd5) || EXP_LOW[cnt[2:0]];
  // Completion only counts while a request is actually outstanding.
  assign mul_go    = pend && bus.mul_done;
  assign acc_bytes = fe_tobytes(acc);

  assign bus.s         = s_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.mul_valid = mv_r;
  assign bus.mul_op_a  = op_a;
  assign bus.mul_op_b  = op_b;

  // Sequencer: accept, inversion ladder, the two final products, then pack.
  // The running power is never stored: it is always the last multiplier result,
  // and after the ladder the reciprocal stays parked on mul_op_b for both products.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 8'd254;
      pend   <= 1'b0;
      x_l    <= '0;
      y_l    <= '0;
      z_l    <= '0;
      acc    <= '0;
      xneg   <= 1'b0;
      s_r    <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
      mv_r   <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
    end else begin
      mv_r   <= 1'b0;
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= 8'd254;
          busy_r <= 1'b0;
          // busy is still high in the done cycle, so a request there waits.
          if (bus.valid && !busy_r) begin
            x_l    <= bus.h_x;
            y_l    <= bus.h_y;
            z_l    <= bus.h_z;
            op_a   <= bus.h_z;
            op_b   <= bus.h_z;
            mv_r   <= 1'b1;
            pend   <= 1'b1;
            busy_r <= 1'b1;
            cnt    <= 8'd253;
            state  <= INV_SQ;
          end
        end
        INV_SQ: begin
          if (mul_go) begin
            mv_r <= 1'b1;
            pend <= 1'b1;
            if (cur_bit) begin
              op_a  <= bus.mul_res;
              op_b  <= z_l;
              state <= INV_MUL;
            end else if (cnt == 8'd0) begin
              op_a  <= x_l;
              op_b  <= bus.mul_res;
              state <= MUL_X;
            end else begin
              cnt  <= cnt - 8'd1;
              op_a <= bus.mul_res;
              op_b <= bus.mul_res;
            end
          end
        end
        INV_MUL: begin
          if (mul_go) begin
            mv_r <= 1'b1;
            pend <= 1'b1;
            if (cnt == 8'd0) begin
              op_a  <= x_l;
              op_b  <= bus.mul_res;
              state <= MUL_X;
            end else begin
              cnt   <= cnt - 8'd1;
              op_a  <= bus.mul_res;
              op_b  <= bus.mul_res;
              state <= INV_SQ;
            end
          end
        end
        MUL_X: begin
          if (mul_go) begin
            acc   <= bus.mul_res;
            op_a  <= y_l;
            mv_r  <= 1'b1;
            pend  <= 1'b1;
            state <= MUL_Y;
          end
        end
        MUL_Y: begin
          if (mul_go) begin
            xneg  <= fe_isnegative(acc);
            acc   <= bus.mul_res;
            pend  <= 1'b0;
            state <= PACK;
          end
        end
        PACK: begin
          s_r    <= (acc_bytes & PAYLOAD_MASK) | {xneg, 255'd0};
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ge_p3_tobytes.sv
// Directed bench for ge_p3_tobytes with a behavioural field multiplier of
// programmable latency and a queue-based result scoreboard.
module tb_ge_p3_tobytes;
  localparam logic [255:0] P    = 256'h7fffffffffffffff_ffffffffffffffff_ffffffffffffffff_ffffffffffffffed;
  localparam logic [255:0] BX   = 256'h216936d3cd6e53fe_c0a4e231fdd6dc5c_692cc7609525a7b2_c9562d608f25d51a;
  localparam logic [255:0] BY   = 256'h6666666666666666_6666666666666666_6666666666666666_6666666666666658;
  localparam logic [255:0] S_B  = 256'h6666666666666666_6666666666666666_6666666666666666_6666666666666658;
  localparam logic [255:0] S_NB = 256'he666666666666666_6666666666666666_6666666666666666_6666666666666658;
  localparam int LAT1 = 508 * 2 + 2;
  localparam int LAT5 = 508 * 6 + 2;

  logic clk;
  logic rst;
  ge_p3_tobytes_if bus ();

  ge_p3_tobytes dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int failed   = 0;
  int muls     = 0;
  int mul_lat  = 1;

  // Scoreboard queues: name, expected s, expected latency (-1: unchecked), accept cycle.
  string         qn [$];
  logic [255:0]  qs [$];
  int            ql [$];
  int            qa [$];

  function automatic logic [319:0] to_limbs(input logic [255:0] v);
    logic [319:0] r;
    logic [255:0] t;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      t = v >> (25*i + (i+1)/2);
      t = t & ((i % 2 == 0) ? ((256'd1 << 26) - 256'd1) : ((256'd1 << 25) - 256'd1));
      r[32*i +: 32] = t[31:0];
    end
    return r;
  endfunction

  function automatic logic [255:0] from_limbs(input logic [319:0] h);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) v = v + ({480'd0, h[32*i +: 32]} << (25*i + (i+1)/2));
    v = v % {256'd0, P};
    return v[255:0];
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] pr;
    pr = {256'd0, a} * {256'd0, b};
    pr = pr % {256'd0, P};
    return pr[255:0];
  endfunction

  task automatic check(input string nm, input logic [319:0] got, input logic [319:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    compared++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    end
  endtask

  // Field multiplier: result and done strobe mul_lat cycles after the request.
  int           cd = 0;
  logic [319:0] pend_res = '0;
  always @(negedge clk) begin
    bus.mul_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.mul_done = 1'b1;
        bus.mul_res  = pend_res;
      end
    end
    if (bus.mul_valid === 1'b1) begin
      pend_res = to_limbs(fmul(from_limbs(bus.mul_op_a), from_limbs(bus.mul_op_b)));
      cd = mul_lat;
    end
  end

  // Monitor: counts requests and checks every done pulse against the queue head.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    string        nm;
    logic [255:0] es;
    int           el;
    int           ea;
    if (bus.mul_valid === 1'b1) muls++;
    if (bus.done === 1'b1) begin
      if (qs.size() == 0) begin
        compared++;
        failed++;
        $display("FAIL unexpected_done: got done=1 with s=%h, required no done", bus.s);
      end else begin
        nm = qn.pop_front();
        es = qs.pop_front();
        el = ql.pop_front();
        ea = qa.pop_front();
        check({nm, "_s"}, {64'd0, bus.s}, {64'd0, es});
        check_int({nm, "_mul_count"}, muls, 508);
        check_int({nm, "_busy_in_done"}, int'(bus.busy), 1);
        check_int({nm, "_single_pulse"}, int'(prev_done), 0);
        if (el >= 0) check_int({nm, "_latency"}, cyc - ea, el);
      end
      muls = 0;
    end
    prev_done = bus.done;
  end

  task automatic set_point(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z);
    bus.h_x = to_limbs(x);
    bus.h_y = to_limbs(y);
    bus.h_z = to_limbs(z);
  endtask

  task automatic push(input string nm, input logic [255:0] s, input int lat, input int acc);
    qn.push_back(nm);
    qs.push_back(s);
    ql.push_back(lat);
    qa.push_back(acc);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      failed++;
      $display("FAIL idle_timeout: got busy=%b after 5000 cycles, required 0", bus.busy);
    end
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      compared++;
      failed++;
      $display("FAIL %s_timeout: got no done in 5000 cycles, required done", nm);
    end
  endtask

  task automatic issue(input string nm, input logic [255:0] x, input logic [255:0] y,
                       input logic [255:0] z, input logic [255:0] exp_s, input int lat,
                       input bit track);
    bit ok;
    wait_idle(ok);
    if (ok) begin
      set_point(x, y, z);
      bus.valid = 1'b1;
      muls = 0;
      if (track) push(nm, exp_s, lat, cyc);
      @(negedge clk);
      bus.valid = 1'b0;
      set_point(256'd5, 256'd9, 256'd3);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 5000 && qs.size() != 0; i++) @(negedge clk);
    if (qs.size() != 0) begin
      compared++;
      failed++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", qs.size());
      qn.delete(); qs.delete(); ql.delete(); qa.delete();
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_s"}, {64'd0, bus.s}, 320'd0);
    check_int({nm, "_done"}, int'(bus.done), 0);
    check_int({nm, "_busy"}, int'(bus.busy), 0);
    check_int({nm, "_mul_valid"}, int'(bus.mul_valid), 0);
    check({nm, "_mul_op_a"}, bus.mul_op_a, 320'd0);
    check({nm, "_mul_op_b"}, bus.mul_op_b, 320'd0);
  endtask

  // Watchdog against a hung handshake.
  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test by 60000 cycles, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] x7, y7;
    int k;
    rst = 1'b0;
    bus.valid = 1'b0;
    set_point(256'd0, 256'd0, 256'd0);
    x7 = fmul(256'd7, BX);
    y7 = fmul(256'd7, BY);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    mul_lat = 1;
    issue("base_B", BX, BY, 256'd1, S_B, LAT1, 1'b1);
    issue("identity", 256'd0, 256'd1, 256'd1, 256'd1, LAT1, 1'b1);
    issue("B_scaled_7", x7, y7, 256'd7, S_B, LAT1, 1'b1);
    issue("neg_B", P - BX, BY, 256'd1, S_NB, LAT1, 1'b1);
    drain();

    // Abort after 100 multiplies; the pending result lands while the next request is taken.
    issue("aborted", x7, y7, 256'd7, 256'd0, LAT1, 1'b0);
    k = 0;
    for (int i = 0; i < 5000 && k < 100; i++) begin
      @(negedge clk);
      if (bus.mul_valid === 1'b1) k++;
    end
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b1;
    set_point(BX, BY, 256'd1);
    bus.valid = 1'b1;
    muls = 0;
    push("after_reset", S_B, LAT1, cyc);
    @(negedge clk);
    bus.valid = 1'b0;
    drain();

    issue("z_zero_L1", BX, BY, 256'd0, 256'd0, LAT1, 1'b1);
    drain();
    mul_lat = 5;
    issue("z_zero_L5", x7, y7, 256'd0, 256'd0, LAT5, 1'b1);
    drain();
    mul_lat = 1;

    // valid held high: inputs change mid-operation, second op picks them up after done.
    begin
      bit ok;
      wait_idle(ok);
      set_point(x7, y7, 256'd7);
      bus.valid = 1'b1;
      muls = 0;
      push("held_first", S_B, LAT1, cyc);
      push("held_second", 256'd1, -1, 0);
      repeat (50) @(negedge clk);
      set_point(256'd0, 256'd1, 256'd1);
      wait_done("held_first");
      wait_done("held_second");
      bus.valid = 1'b0;
    end
    drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
